// File: rtl/ysyx_22040895_mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Optional macro YSYX_22040895_MDU_FASTPATH_EN sends trivial ops straight from IDLE to DONE.
module ysyx_22040895_mdu_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      mduop_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int unsigned HW = XLEN / 2;
    localparam int unsigned DW = 2 * XLEN;
    localparam int unsigned CW = 7;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [3:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q, r_neg_r, r_dz, r_valid;
    logic [DW-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0] r_mplier, r_rem, r_quo, r_dvsr, r_result;

    logic            w_legal, w_mul, w_word, w_sgn_a, w_sgn_b;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic            w_a_neg, w_b_neg, w_b_zero, w_accept, w_fast, w_is_mul;
    logic [XLEN:0]   w_rem_sh, w_diff;
    logic            w_ge;
    logic [DW-1:0]   w_prod;
    logic [XLEN-1:0] w_quo, w_remv, w_fix_result;

    // Operation decode of the incoming request
    always_comb begin
        w_legal = 1'b1;
        w_mul   = 1'b0;
        w_word  = 1'b0;
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (mduop_i)
            4'd1, 4'd2:   begin w_mul = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            4'd3:         begin w_mul = 1'b1; w_sgn_a = 1'b1; end
            4'd4:         w_mul = 1'b1;
            4'd5, 4'd7:   begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            4'd6, 4'd8:   ;
            4'd9:         begin w_mul = 1'b1; w_word = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            4'd10, 4'd12: begin w_word = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            4'd11, 4'd13: w_word = 1'b1;
            default:      w_legal = 1'b0;
        endcase
    end

    // Word ops see only bits [31:0], extended according to signedness
    assign w_a_ext = !w_word ? op1_i :
                     (w_sgn_a ? {{HW{op1_i[HW-1]}}, op1_i[HW-1:0]} : {{HW{1'b0}}, op1_i[HW-1:0]});
    assign w_b_ext = !w_word ? op2_i :
                     (w_sgn_b ? {{HW{op2_i[HW-1]}}, op2_i[HW-1:0]} : {{HW{1'b0}}, op2_i[HW-1:0]});
    assign w_a_neg  = w_sgn_a & w_a_ext[XLEN-1];
    assign w_b_neg  = w_sgn_b & w_b_ext[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == '0);
    assign w_accept = (r_state == S_IDLE) & valid_i & w_legal & ~flush_i;

`ifdef YSYX_22040895_MDU_FASTPATH_EN
    logic [XLEN-1:0] w_a_sx, w_min, w_fast_result;
    logic            w_a_zero, w_ovf, w_is_rem;

    assign w_a_sx   = w_word ? {{HW{op1_i[HW-1]}}, op1_i[HW-1:0]} : op1_i;
    assign w_min    = w_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_a_zero = (w_a_ext == '0);
    assign w_ovf    = ~w_mul & w_sgn_a & w_sgn_b & (w_a_ext == w_min) & (w_b_ext == '1);
    assign w_is_rem = (mduop_i == 4'd7) | (mduop_i == 4'd8) | (mduop_i == 4'd12) | (mduop_i == 4'd13);
    assign w_fast   = w_mul ? (w_a_zero | w_b_zero) : (w_b_zero | w_ovf);

    // Architectural results for the short-circuited cases
    always_comb begin
        w_fast_result = '0;
        if (!w_mul) begin
            if (w_b_zero)
                w_fast_result = w_is_rem ? w_a_sx : '1;
            else
                w_fast_result = w_is_rem ? '0 : w_a_sx;
        end
    end
`else
    assign w_fast = 1'b0;
`endif

    assign w_is_mul = (r_op == 4'd1) | (r_op == 4'd2) | (r_op == 4'd3) | (r_op == 4'd4) | (r_op == 4'd9);

    // Restoring-divide step on the XLEN+1 bit shifted partial remainder
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge     = ~w_diff[XLEN];

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_remv = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            4'd1:               w_fix_result = w_prod[XLEN-1:0];
            4'd2, 4'd3, 4'd4:   w_fix_result = w_prod[DW-1:XLEN];
            4'd9:               w_fix_result = {{HW{w_prod[HW-1]}}, w_prod[HW-1:0]};
            4'd5, 4'd6:         w_fix_result = w_quo;
            4'd10, 4'd11:       w_fix_result = {{HW{w_quo[HW-1]}}, w_quo[HW-1:0]};
            4'd7, 4'd8:         w_fix_result = w_remv;
            4'd12, 4'd13:       w_fix_result = {{HW{w_remv[HW-1]}}, w_remv[HW-1:0]};
            default:            w_fix_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)                w_next = S_IDLE;
                else if (r_cnt == CW'(1))   w_next = S_FIX;
            end
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: if (flush_i || ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_valid  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op     <= mduop_i;
                    r_cnt    <= w_word ? CW'(HW) : CW'(XLEN);
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_dz     <= w_b_zero;
                    r_acc    <= '0;
                    r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                    r_mplier <= w_b_mag;
                    r_rem    <= '0;
                    r_quo    <= w_word ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
                    r_dvsr   <= w_b_mag;
`ifdef YSYX_22040895_MDU_FASTPATH_EN
                    if (w_fast) begin
                        r_result <= w_fast_result;
                        r_valid  <= 1'b1;
                    end
`endif
                end
                S_CALC: if (!flush_i) begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_is_mul) begin
                        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                    end
                end
                S_FIX: if (!flush_i) begin
                    r_result <= w_fix_result;
                    r_valid  <= 1'b1;
                end
                S_DONE: if (flush_i || ready_i) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = (r_state != S_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: tb/tb_ysyx_22040895_mdu_seq.sv
// Randomized self-checking bench for ysyx_22040895_mdu_seq against an arithmetic RV64M model.
module tb_ysyx_22040895_mdu_seq;
    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [3:0]  mduop_i;
    logic [63:0] op1_i, op2_i, result_o;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22040895_mdu_seq dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .mduop_i(mduop_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    function automatic logic [63:0] ref_mdu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        logic [127:0]        pu;
        longint              sa, sb;
        int                  a32, b32;
        logic [31:0]         ua, ub, w;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; ua = a[31:0]; ub = b[31:0];
        case (op)
            4'd1: return a * b;
            4'd2: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
            4'd3: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b}; p = pa * pb; return p[127:64]; end
            4'd4: begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
            4'd5: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return 64'(sa / sb);
            end
            4'd6: return (b == 0) ? '1 : a / b;
            4'd7: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                return 64'(sa % sb);
            end
            4'd8: return (b == 0) ? a : a % b;
            4'd9: begin w = ua * ub; return sx32(w); end
            4'd10: begin
                if (b32 == 0) return '1;
                if (a32 == 32'sh8000_0000 && b32 == -1) return sx32(ua);
                w = 32'(a32 / b32); return sx32(w);
            end
            4'd11: begin
                if (ub == 0) return '1;
                w = ua / ub; return sx32(w);
            end
            4'd12: begin
                if (b32 == 0) return sx32(ua);
                if (a32 == 32'sh8000_0000 && b32 == -1) return 64'd0;
                w = 32'(a32 % b32); return sx32(w);
            end
            4'd13: begin
                if (ub == 0) return sx32(ua);
                w = ua % ub; return sx32(w);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Edges from the accepting edge (counted as 1) to valid_o high
    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit word;
        word = (op >= 4'd9);
`ifdef YSYX_22040895_MDU_FASTPATH_EN
        begin
            logic [63:0] ea, eb, mn;
            bit is_mul, sgn;
            ea = word ? sx32(a[31:0]) : a;
            eb = word ? sx32(b[31:0]) : b;
            mn = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
            is_mul = (op <= 4'd4) || (op == 4'd9);
            sgn = (op == 4'd5) || (op == 4'd7) || (op == 4'd10) || (op == 4'd12);
            if (is_mul && (ea == 0 || eb == 0)) return 1;
            if (!is_mul && (eb == 0 || (sgn && ea == mn && eb == '1))) return 1;
        end
`endif
        return word ? 34 : 66;
    endfunction

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_8000_0000;
            5: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp, held;
        int          edges;
        bit          hs_bad, hold_bad;
        exp = ref_mdu(op, a, b);
        @(negedge clk);
        check("ready_idle", 64'(ready_o), 64'd1);
        valid_i = 1'b1; mduop_i = op; op1_i = a; op2_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        op1_i = {$urandom, $urandom}; op2_i = {$urandom, $urandom};
        mduop_i = 4'($urandom_range(1, 13));
        edges = 1; hs_bad = 1'b0; hold_bad = 1'b0;
        while (!valid_o && edges < 200) begin
            if (ready_o || !busy_o) hs_bad = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("latency op%0d", op), 64'(edges), 64'(ref_lat(op, a, b)));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), result_o, exp);
        check("busy_during_op", 64'(hs_bad), 64'd0);
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!valid_o || result_o !== held || ready_o) hold_bad = 1'b1;
        end
        if (hold > 0) check("hold_stable", 64'(hold_bad), 64'd0);
        @(negedge clk); ready_i = 1'b1;
        @(posedge clk); #1; ready_i = 1'b0;
        check("release", 64'({valid_o, ready_o, busy_o}), 64'b010);
    endtask

    initial begin
        int edges;
        bit seen;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        mduop_i = 4'd0; op1_i = '0; op2_i = '0;
        #12;
        check("rst_state", 64'({valid_o, busy_o}), 64'd0);
        check("rst_result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("post_rst_ready", 64'({ready_o, busy_o}), 64'b10);

        run_op(4'd1,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5);
        run_op(4'd10, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        run_op(4'd12, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        run_op(4'd6,  64'd100, 64'd0, 0);
        run_op(4'd8,  64'd100, 64'd0, 2);
        run_op(4'd5,  64'h8000_0000_0000_0000, '1, 0);
        run_op(4'd7,  64'h8000_0000_0000_0000, '1, 0);
        run_op(4'd4,  '1, '1, 0);
        run_op(4'd10, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op(4'd13, 64'hAAAA_AAAA_8765_4321, 64'hFFFF_FFFF_0000_0000, 0);
        run_op(4'd3,  64'hFFFF_FFFF_FFFF_FFFE, '1, 1);

        // Illegal op and flush in IDLE are both refused
        @(negedge clk); valid_i = 1'b1; mduop_i = 4'd14; op1_i = 64'd3; op2_i = 64'd4;
        @(posedge clk); #1; check("illegal_busy", 64'(busy_o), 64'd0);
        @(negedge clk); mduop_i = 4'd0;
        @(posedge clk); #1; check("op0_busy", 64'(busy_o), 64'd0);
        @(negedge clk); mduop_i = 4'd1; flush_i = 1'b1;
        @(posedge clk); #1; check("flush_idle_busy", 64'(busy_o), 64'd0);
        valid_i = 1'b0; flush_i = 1'b0;

        // Flush during the 10th CALC cycle
        @(negedge clk); valid_i = 1'b1; mduop_i = 4'd6; op1_i = 64'd1000; op2_i = 64'd7;
        @(posedge clk); #1; valid_i = 1'b0;
        for (int i = 0; i < 9; i++) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0;
        check("flush_calc", 64'({valid_o, ready_o, busy_o}), 64'b010);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (valid_o || busy_o) seen = 1'b1; end
        check("flush_no_valid", 64'(seen), 64'd0);

        run_op(4'd2, 64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk); valid_i = 1'b1; mduop_i = 4'd1; op1_i = 64'd5; op2_i = 64'd9;
        @(posedge clk); #1; valid_i = 1'b0;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_flags", 64'({valid_o, ready_o, busy_o}), 64'b010);
        check("async_rst_result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int n = 0; n < 40; n++)
            run_op(4'($urandom_range(1, 13)), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3));

        edges = n_checks;
        $display("CHECKS %0d ERRORS %0d", edges, n_errors);
        $finish;
    end
endmodule
